// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ==========================================================================
// seg7_scan_driver : 4-digit common-anode seven-segment scan driver with
//                    anti-ghosting dead time and frame-synchronous loading.
// Revision         : 1.0
// ==========================================================================
module seg7_scan_driver #(
  parameter int CLK_DIV = 100000,
  parameter int DEAD    = 16
) (
  input  logic        clk_100mhz,
  input  logic        rst,
  input  logic [15:0] disp_data,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  input  logic        load,
  output logic [3:0]  AN,
  output logic [7:0]  SEGMENT,
  output logic        pending,
  output logic        frame_done
);

  localparam int            CW      = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_digit;
  logic [15:0]   r_data;
  logic [3:0]    r_dp;
  logic [3:0]    r_blank;
  logic [15:0]   r_pend_data;
  logic [3:0]    r_pend_dp;
  logic [3:0]    r_pend_blank;
  logic          r_pending;
  logic          r_frame_done;
  logic [3:0]    r_an;
  logic [7:0]    r_seg;

  logic          w_wrap;
  logic          w_boundary;
  logic          w_dead;
  logic [3:0]    w_nibble;
  logic [3:0]    w_an_next;
  logic [7:0]    w_seg_next;

  // Active-low segments {g,f,e,d,c,b,a}
  function automatic logic [6:0] hexdec(input logic [3:0] n);
    case (n)
      4'h0: hexdec = 7'h40;
      4'h1: hexdec = 7'h79;
      4'h2: hexdec = 7'h24;
      4'h3: hexdec = 7'h30;
      4'h4: hexdec = 7'h19;
      4'h5: hexdec = 7'h12;
      4'h6: hexdec = 7'h02;
      4'h7: hexdec = 7'h78;
      4'h8: hexdec = 7'h00;
      4'h9: hexdec = 7'h10;
      4'hA: hexdec = 7'h08;
      4'hB: hexdec = 7'h03;
      4'hC: hexdec = 7'h46;
      4'hD: hexdec = 7'h21;
      4'hE: hexdec = 7'h06;
      default: hexdec = 7'h0E;
    endcase
  endfunction

  assign w_wrap     = (r_cnt == CNT_MAX);
  assign w_boundary = w_wrap && (r_digit == 2'd3);
  assign w_nibble   = r_data[{r_digit, 2'b00} +: 4];

  // With no dead time the anodes are never forced off.
  generate
    if (DEAD == 0) begin : g_no_dead
      assign w_dead = 1'b0;
    end else begin : g_dead
      localparam logic [CW-1:0] DEAD_CNT = CW'(DEAD);
      assign w_dead = (r_cnt < DEAD_CNT);
    end
  endgenerate

  always_comb begin
    w_an_next  = 4'b1111;
    w_seg_next = 8'hFF;
    if (!w_dead && !r_blank[r_digit]) begin
      w_an_next  = ~(4'b0001 << r_digit);
      w_seg_next = {~r_dp[r_digit], hexdec(w_nibble)};
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      r_cnt        <= '0;
      r_digit      <= 2'd0;
      r_data       <= 16'h0000;
      r_dp         <= 4'h0;
      r_blank      <= 4'h0;
      r_pend_data  <= 16'h0000;
      r_pend_dp    <= 4'h0;
      r_pend_blank <= 4'h0;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
      r_an         <= 4'b1111;
      r_seg        <= 8'hFF;
    end else begin
      r_cnt        <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_wrap) begin
        r_digit <= r_digit + 2'd1;
      end
      r_an         <= w_an_next;
      r_seg        <= w_seg_next;
      r_frame_done <= w_boundary;
      // A load landing on the boundary bypasses the pending buffer entirely.
      if (load && w_boundary) begin
        r_data    <= disp_data;
        r_dp      <= dp_in;
        r_blank   <= blank_in;
        r_pending <= 1'b0;
      end else if (load) begin
        r_pend_data  <= disp_data;
        r_pend_dp    <= dp_in;
        r_pend_blank <= blank_in;
        r_pending    <= 1'b1;
      end else if (w_boundary && r_pending) begin
        r_data    <= r_pend_data;
        r_dp      <= r_pend_dp;
        r_blank   <= r_pend_blank;
        r_pending <= 1'b0;
      end
    end
  end

  assign AN         = r_an;
  assign SEGMENT    = r_seg;
  assign pending    = r_pending;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ==========================================================================
// tb_seg7_scan_driver : self-checking bench for seg7_scan_driver (CLK_DIV=8,
//                       DEAD=2, 32-cycle frames).
// Revision            : 1.0
// ==========================================================================
module tb_seg7_scan_driver;

  logic        clk_100mhz = 1'b0;
  logic        rst;
  logic [15:0] disp_data;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        load;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        pending;
  logic        frame_done;

  seg7_scan_driver #(.CLK_DIV(8), .DEAD(2)) dut (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .disp_data  (disp_data),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .load       (load),
    .AN         (an),
    .SEGMENT    (seg),
    .pending    (pending),
    .frame_done (frame_done)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [31:0] seg;   // {digit3, digit2, digit1, digit0}
    logic [15:0] an;    // {digit3, digit2, digit1, digit0}
  } vec_t;

  typedef struct {
    int         p;
    logic [3:0] an;
    logic [7:0] seg;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   tcnt     = 0;   // edges since reset release; outputs then show slot position tcnt-1

  always @(posedge clk_100mhz) begin
    if (rst) tcnt <= 0;
    else     tcnt <= tcnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t tcnt=%0d: got %0h expected %0h", name, $time, tcnt, act, exp);
    end
  endtask

  // Expected scan for one frame: both dead cycles and first/last active cycle of each slot.
  task automatic push_frame(input int f, input vec_t v);
    for (int d = 0; d < 4; d++) begin
      sb.push_back('{f + 8*d + 0, 4'b1111, 8'hFF});
      sb.push_back('{f + 8*d + 1, 4'b1111, 8'hFF});
      sb.push_back('{f + 8*d + 2, v.an[4*d +: 4], v.seg[8*d +: 8]});
      sb.push_back('{f + 8*d + 7, v.an[4*d +: 4], v.seg[8*d +: 8]});
    end
  endtask

  always @(negedge clk_100mhz) begin
    if (tcnt >= 1) begin
      check("frame_done", {31'd0, frame_done}, {31'd0, (tcnt % 32) == 0});
      while (sb.size() > 0 && sb[0].p < tcnt - 1) begin
        checks++;
        failures++;
        $display("FAIL sb_missed: slot %0d not observed, now at %0d", sb[0].p, tcnt - 1);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].p == tcnt - 1) begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("AN_p%0d", e.p), {28'd0, an}, {28'd0, e.an});
        check($sformatf("SEGMENT_p%0d", e.p), {24'd0, seg}, {24'd0, e.seg});
      end
    end
  end

  task automatic step_to(input int target);
    int budget;
    budget = 400;
    while (tcnt != target && budget > 0) begin
      @(posedge clk_100mhz); #1;
      budget--;
    end
    if (tcnt != target) begin
      checks++;
      failures++;
      $display("FAIL step_to: tcnt=%0d target=%0d", tcnt, target);
    end
  endtask

  task automatic drive_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] b);
    disp_data = d;
    dp_in     = dp;
    blank_in  = b;
    load      = 1'b1;
    @(posedge clk_100mhz); #1;
    load      = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    vec_t zero_v;
    vec_t two_v;
    int   target;
    int   f;
    int   fg;
    int   fc;
    int   budget;

    vecs[0] = '{16'h3A0F, 4'b0000, 4'b0000, {8'hB0, 8'h88, 8'hC0, 8'h8E}, {4'b0111, 4'b1011, 4'b1101, 4'b1110}};
    vecs[1] = '{16'h0000, 4'b0001, 4'b0100, {8'hC0, 8'hFF, 8'hC0, 8'h40}, {4'b0111, 4'b1111, 4'b1101, 4'b1110}};
    vecs[2] = '{16'h7654, 4'b0000, 4'b0000, {8'hF8, 8'h82, 8'h92, 8'h99}, {4'b0111, 4'b1011, 4'b1101, 4'b1110}};
    vecs[3] = '{16'hBA98, 4'b1010, 4'b0000, {8'h03, 8'h88, 8'h10, 8'h80}, {4'b0111, 4'b1011, 4'b1101, 4'b1110}};
    vecs[4] = '{16'hFEDC, 4'b0000, 4'b1001, {8'hFF, 8'h86, 8'hA1, 8'hFF}, {4'b1111, 4'b1011, 4'b1101, 4'b1111}};
    vecs[5] = '{16'h1C1C, 4'b0100, 4'b0000, {8'hF9, 8'h46, 8'hF9, 8'hC6}, {4'b0111, 4'b1011, 4'b1101, 4'b1110}};
    zero_v  = '{16'h0000, 4'b0000, 4'b0000, {8'hC0, 8'hC0, 8'hC0, 8'hC0}, {4'b0111, 4'b1011, 4'b1101, 4'b1110}};
    two_v   = '{16'h2222, 4'b0000, 4'b0000, {8'hA4, 8'hA4, 8'hA4, 8'hA4}, {4'b0111, 4'b1011, 4'b1101, 4'b1110}};

    rst       = 1'b1;
    load      = 1'b0;
    disp_data = 16'h0000;
    dp_in     = 4'h0;
    blank_in  = 4'h0;
    repeat (3) @(posedge clk_100mhz);
    #1;
    check("reset_AN", {28'd0, an}, 32'hF);
    check("reset_SEGMENT", {24'd0, seg}, 32'hFF);
    check("reset_pending", {31'd0, pending}, 32'd0);
    check("reset_frame_done", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;
    push_frame(0, zero_v);

    // Each load lands mid-frame and must appear only from the next frame boundary.
    for (int i = 0; i < 6; i++) begin
      target = (tcnt / 32) * 32 + 10;
      if (target <= tcnt) target += 32;
      step_to(target);
      drive_load(vecs[i].data, vecs[i].dp, vecs[i].blank);
      check($sformatf("pending_set_v%0d", i), {31'd0, pending}, 32'd1);
      f = (tcnt / 32 + 1) * 32;
      push_frame(f, vecs[i]);
      step_to(f);
      check($sformatf("pending_clear_v%0d", i), {31'd0, pending}, 32'd0);
    end

    // Two loads in one frame: the later one wins, the earlier is never shown.
    fg = tcnt;
    step_to(fg + 5);
    drive_load(16'h1111, 4'h0, 4'h0);
    check("db_pending_first", {31'd0, pending}, 32'd1);
    step_to(fg + 20);
    drive_load(16'h2222, 4'h0, 4'h0);
    push_frame(fg + 32, two_v);
    step_to(fg + 31);
    check("db_pending_before_boundary", {31'd0, pending}, 32'd1);
    step_to(fg + 32);
    check("db_pending_after_boundary", {31'd0, pending}, 32'd0);

    // Load exactly on the boundary edge commits directly.
    fc = fg + 64;
    step_to(fc - 1);
    drive_load(16'h5555, 4'h0, 4'h0);
    check("collision_pending", {31'd0, pending}, 32'd0);
    sb.push_back('{fc + 4,  4'b1110, 8'h92});
    sb.push_back('{fc + 12, 4'b1101, 8'h92});

    // Reset during a digit2 slot with a load pending.
    step_to(fc + 16);
    drive_load(16'h9999, 4'h0, 4'h0);
    check("midrst_pending_before", {31'd0, pending}, 32'd1);
    check("midrst_sb_drained", sb.size(), 32'd0);
    rst = 1'b1;
    @(posedge clk_100mhz); #1;
    check("midrst_AN", {28'd0, an}, 32'hF);
    check("midrst_SEGMENT", {24'd0, seg}, 32'hFF);
    check("midrst_pending", {31'd0, pending}, 32'd0);
    check("midrst_frame_done", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;
    push_frame(0, zero_v);
    push_frame(32, zero_v);
    step_to(64);

    budget = 100;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge clk_100mhz); #1;
      budget--;
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL sb_leftover: %0d expected slots never observed", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
